// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-requester arbiter for a single-port data memory with
//               starvation-bounded priority swap and an m1 exclusive lock.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                    sysclk,
    input  logic                    rst,

    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_lock,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int         c_STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [3:0] c_MAX_WAIT   = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        PRIO0 = 2'd0,
        PRIO1 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_wait_cnt;
    logic [3:0] w_wait_next;
    logic       r_rd_pending;
    logic       r_rd_owner;
    logic       w_gnt0;
    logic       w_gnt1;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            case (r_state)
                PRIO0: begin
                    w_gnt0 = m0_req;
                    w_gnt1 = m1_req & ~m0_req;
                end
                PRIO1: begin
                    w_gnt1 = m1_req;
                    w_gnt0 = m0_req & ~m1_req;
                end
                LOCK1: w_gnt1 = m1_req;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_wait_next = 4'd0;
        if (m1_req && !w_gnt1) begin
            w_wait_next = (r_wait_cnt == 4'hF) ? r_wait_cnt : r_wait_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            PRIO0: begin
                if (w_gnt1 && m1_lock) begin
                    w_state_next = LOCK1;
                end else if (w_wait_next == c_MAX_WAIT) begin
                    w_state_next = PRIO1;
                end
            end
            PRIO1: begin
                if (w_gnt1 && m1_lock) begin
                    w_state_next = LOCK1;
                end else if (w_gnt1 || !m1_req) begin
                    w_state_next = PRIO0;
                end
            end
            LOCK1: begin
                if (!m1_lock) begin
                    w_state_next = PRIO0;
                end
            end
            default: w_state_next = PRIO0;
        endcase
    end

    // The owner bit only matters while a read is pending, so it simply tracks m1's grant.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state      <= PRIO0;
            r_wait_cnt   <= 4'd0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wait_cnt   <= w_wait_next;
            r_rd_pending <= (w_gnt0 & ~m0_we) | (w_gnt1 & ~m1_we);
            r_rd_owner   <= w_gnt1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (w_gnt0) begin
            mem_en    = 1'b1;
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_we ? m0_wstrb : {c_STRB_WIDTH{1'b0}};
        end else if (w_gnt1) begin
            mem_en    = 1'b1;
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_we ? m1_wstrb : {c_STRB_WIDTH{1'b0}};
        end
    end

    // Gating with rst drops a read that was granted just before reset.
    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = r_rd_pending & ~r_rd_owner & ~rst;
    assign m1_rvalid = r_rd_pending &  r_rd_owner & ~rst;
    assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
    assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule
`default_nettype wire
